// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - shared FSM state type and AER handshake timing constants
package aer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HIGH = 2'd1,
    REQ_LOW  = 2'd2
  } aer_tx_state_t;

  localparam int AER_SYNC_STAGES     = 2;
  localparam int AER_DEFAULT_TIMEOUT = 255;

  function automatic int aer_cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic Q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = D;
    sync_d = meta_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign Q = sync_q;

endmodule

// File: rtl/aer_spike_encoder.sv
// rtl/aer_spike_encoder.sv - turns sorted pixel indices into 4-phase AER request/ack events
module aer_spike_encoder
  import aer_pkg::*;
#(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int AER_WIDTH       = 8,
  parameter int ADDR_BASE       = 0,
  parameter int TIMEOUT_CYCLES  = AER_DEFAULT_TIMEOUT
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [IMAGE_SIZE_BITS:0]   NEXT_INDEX,
  input  logic                       FOUND_NEXT_INDEX,
  output logic                       AERIN_CTRL_BUSY,
  output logic [AER_WIDTH-1:0]       AEROUT_ADDR,
  output logic                       AEROUT_REQ,
  input  logic                       AEROUT_ACK,
  output logic [IMAGE_SIZE_BITS:0]   EVENT_COUNT,
  input  logic                       CLEAR,
  output logic                       TIMEOUT_ERR
);

  localparam int                   IW      = IMAGE_SIZE_BITS + 1;
  localparam int                   TW      = aer_cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]        TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AER_WIDTH-1:0] BASE    = AER_WIDTH'(ADDR_BASE);

  aer_tx_state_t        state_q, state_d;
  logic                 req_q, req_d;
  logic                 busy_q, busy_d;
  logic [AER_WIDTH-1:0] addr_q, addr_d;
  logic [IW-1:0]        count_q, count_d;
  logic                 err_q, err_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;

  logic ack_s;
  logic capture, ack_seen, complete, abort;

  sync_2ff u_ack_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (AEROUT_ACK),
    .Q     (ack_s)
  );

  // A stale ACK still high in IDLE blocks capture so the next REQ never overlaps it.
  assign capture  = (state_q == IDLE) && FOUND_NEXT_INDEX && !ack_s;
  assign ack_seen = (state_q == REQ_HIGH) && ack_s;
  assign complete = (state_q == REQ_LOW) && !ack_s;
  assign abort    = (state_q != IDLE) && (to_cnt_q == TO_LAST) && !ack_seen && !complete;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (capture) state_d = REQ_HIGH;
      REQ_HIGH: if (ack_seen) state_d = REQ_LOW;
                else if (abort) state_d = IDLE;
      REQ_LOW:  if (complete || abort) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    if (capture) begin
      addr_d = BASE + AER_WIDTH'(NEXT_INDEX);
      req_d  = 1'b1;
      busy_d = 1'b1;
    end
    if (ack_seen) begin
      req_d = 1'b0;
    end
    if (complete) begin
      busy_d = 1'b0;
      if (count_q != {IW{1'b1}}) count_d = count_q + IW'(1);
    end
    if (abort) begin
      req_d  = 1'b0;
      busy_d = 1'b0;
      err_d  = 1'b1;
    end
    if (CLEAR) begin
      count_d = '0;
      err_d   = 1'b0;
    end
    // Counter restarts on every state change, so each handshake phase gets its own budget.
    to_cnt_d = ((state_d != state_q) || (state_q == IDLE)) ? '0 : to_cnt_q + TW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      req_q    <= req_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign AEROUT_REQ      = req_q;
  assign AERIN_CTRL_BUSY = busy_q;
  assign AEROUT_ADDR     = addr_q;
  assign EVENT_COUNT     = count_q;
  assign TIMEOUT_ERR     = err_q;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// tb/tb_aer_spike_encoder.sv - self-checking bench for aer_spike_encoder
module tb_aer_spike_encoder;

  localparam int IS   = 5;
  localparam int ISB  = 3;
  localparam int AW   = 8;
  localparam int BASE = 16;
  localparam int TO   = 16;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [ISB:0]  NEXT_INDEX = '0;
  logic          FOUND_NEXT_INDEX = 1'b0;
  logic          AERIN_CTRL_BUSY;
  logic [AW-1:0] AEROUT_ADDR;
  logic          AEROUT_REQ;
  logic          AEROUT_ACK = 1'b0;
  logic [ISB:0]  EVENT_COUNT;
  logic          CLEAR = 1'b0;
  logic          TIMEOUT_ERR;

  always #5 CLK = ~CLK;

  aer_spike_encoder #(
    .IMAGE_SIZE      (IS),
    .IMAGE_SIZE_BITS (ISB),
    .AER_WIDTH       (AW),
    .ADDR_BASE       (BASE),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .NEXT_INDEX       (NEXT_INDEX),
    .FOUND_NEXT_INDEX (FOUND_NEXT_INDEX),
    .AERIN_CTRL_BUSY  (AERIN_CTRL_BUSY),
    .AEROUT_ADDR      (AEROUT_ADDR),
    .AEROUT_REQ       (AEROUT_REQ),
    .AEROUT_ACK       (AEROUT_ACK),
    .EVENT_COUNT      (EVENT_COUNT),
    .CLEAR            (CLEAR),
    .TIMEOUT_ERR      (TIMEOUT_ERR)
  );

  typedef struct {
    logic [ISB:0]  idx;
    int            delay;
    logic [AW-1:0] exp_addr;
    logic [ISB:0]  exp_count;
  } vec_t;

  vec_t          tbl[5];
  logic [AW-1:0] sb[$];
  int            n_vec = 0;
  int            n_miss = 0;
  int            cnt_exp = 0;
  logic          err_exp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic strobe(input logic [ISB:0] idx, input logic [AW-1:0] exp_addr, input bit accept);
    NEXT_INDEX       = idx;
    FOUND_NEXT_INDEX = 1'b1;
    if (accept) sb.push_back(exp_addr);
    tick();
    FOUND_NEXT_INDEX = 1'b0;
    NEXT_INDEX       = '0;
  endtask

  task automatic pop_addr(input string nm);
    logic [AW-1:0] e;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard empty, got addr %0d", nm, AEROUT_ADDR);
    end else begin
      e = sb.pop_front();
      chk(nm, AEROUT_ADDR, e);
    end
  endtask

  task automatic handshake(input int ack_delay, input bit clr, input bit poke);
    int n;
    logic [AW-1:0] a0;
    chk("req_rise", AEROUT_REQ, 1);
    chk("busy_rise", AERIN_CTRL_BUSY, 1);
    a0 = AEROUT_ADDR;
    pop_addr("addr");
    if (poke) begin
      NEXT_INDEX = 4'd7;
      FOUND_NEXT_INDEX = 1'b1;
      tick();
      FOUND_NEXT_INDEX = 1'b0;
      NEXT_INDEX = '0;
      chk("addr_ignore_busy_strobe", AEROUT_ADDR, a0);
    end
    repeat (ack_delay) tick();
    chk("req_hold", AEROUT_REQ, 1);
    AEROUT_ACK = 1'b1;
    n = 0;
    while (AEROUT_REQ && n < 40) begin tick(); n++; end
    chk("ack_to_req_fall", n, 3);
    chk("busy_held", AERIN_CTRL_BUSY, 1);
    AEROUT_ACK = 1'b0;
    n = 0;
    while (AERIN_CTRL_BUSY && n < 40) begin
      tick();
      n++;
      CLEAR = clr && (n == 2);
    end
    CLEAR = 1'b0;
    chk("release_to_done", n, 3);
    cnt_exp = clr ? 0 : ((cnt_exp < 15) ? cnt_exp + 1 : 15);
    if (clr) err_exp = 1'b0;
    chk("event_count", EVENT_COUNT, cnt_exp);
    chk("timeout_err", TIMEOUT_ERR, err_exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{4'd1, 1, 8'd17, 4'd1};
    tbl[1] = '{4'd2, 5, 8'd18, 4'd2};
    tbl[2] = '{4'd4, 0, 8'd20, 4'd3};
    tbl[3] = '{4'd0, 3, 8'd16, 4'd4};
    tbl[4] = '{4'd3, 2, 8'd19, 4'd5};

    repeat (3) tick();
    chk("rst_req", AEROUT_REQ, 0);
    chk("rst_busy", AERIN_CTRL_BUSY, 0);
    chk("rst_addr", AEROUT_ADDR, 0);
    chk("rst_count", EVENT_COUNT, 0);
    chk("rst_err", TIMEOUT_ERR, 0);
    RST_N = 1'b1;
    tick();

    strobe(4'd3, AW'(BASE + 3), 1'b1);
    handshake(4, 1'b0, 1'b1);

    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    cnt_exp = 0;
    chk("clear_count", EVENT_COUNT, 0);

    for (int i = 0; i < 5; i++) begin
      strobe(tbl[i].idx, tbl[i].exp_addr, 1'b1);
      handshake(tbl[i].delay, 1'b0, 1'b0);
      chk("tbl_count", EVENT_COUNT, tbl[i].exp_count);
    end

    AEROUT_ACK = 1'b1;
    repeat (3) tick();
    strobe(4'd4, AW'(BASE + 4), 1'b0);
    repeat (2) tick();
    chk("stale_req", AEROUT_REQ, 0);
    chk("stale_busy", AERIN_CTRL_BUSY, 0);
    chk("stale_err", TIMEOUT_ERR, 0);
    AEROUT_ACK = 1'b0;
    repeat (3) tick();
    chk("stale_req_after_release", AEROUT_REQ, 0);
    strobe(4'd4, 8'd20, 1'b1);
    handshake(2, 1'b0, 1'b0);

    strobe(4'd5, AW'(BASE + 5), 1'b1);
    pop_addr("timeout_addr");
    n = 0;
    while (AEROUT_REQ && n < 40) begin tick(); n++; end
    chk("timeout_req_cycles", n, TO);
    err_exp = 1'b1;
    chk("timeout_err_set", TIMEOUT_ERR, 1);
    chk("timeout_busy", AERIN_CTRL_BUSY, 0);
    chk("timeout_count", EVENT_COUNT, cnt_exp);
    repeat (2) tick();
    chk("timeout_err_sticky", TIMEOUT_ERR, 1);

    strobe(4'd2, 8'd18, 1'b1);
    handshake(3, 1'b1, 1'b0);

    strobe(4'd0, 8'd16, 1'b1);
    handshake(1, 1'b0, 1'b0);
    strobe(4'd1, 8'd17, 1'b1);
    pop_addr("rst_mid_addr");
    tick();
    #2 RST_N = 1'b0;
    #1;
    chk("rst_mid_req", AEROUT_REQ, 0);
    chk("rst_mid_busy", AERIN_CTRL_BUSY, 0);
    chk("rst_mid_addr0", AEROUT_ADDR, 0);
    chk("rst_mid_count", EVENT_COUNT, 0);
    chk("rst_mid_err", TIMEOUT_ERR, 0);
    tick();
    RST_N = 1'b1;
    cnt_exp = 0;
    err_exp = 1'b0;
    tick();
    strobe(4'd4, 8'd20, 1'b1);
    handshake(2, 1'b0, 1'b0);
    chk("post_rst_count", EVENT_COUNT, 1);

    for (int i = 0; i < 16; i++) begin
      strobe(4'(i % 5), AW'(BASE + (i % 5)), 1'b1);
      handshake(0, 1'b0, 1'b0);
    end
    chk("count_saturated", EVENT_COUNT, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
